fp32_div_seq: RTL and testbench

- Multi-cycle IEEE-754 binary32 divider: result = a / b.
- Used in the CG solver ALU for alpha = rsold/(p·Ap) and beta = rsnew/rsold.
- Level-held start/finish handshake: upstream raises `start` with stable operands and holds it; `finish` stays high with a stable quotient until `start` drops.

---
 rtl/fp32_div_seq.sv | 177 +++++++++++++++++
 tb/tb_fp32_div_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp32_div_seq.sv
// fp32_div_seq: multi-cycle IEEE-754 binary32 divider, result = a / b.
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   start   level request: high = compute/hold, low = idle/abort
//   a, b    dividend / divisor (binary32), sampled only on the accepting edge
//   result  quotient (binary32), written once per completed operation
//   finish  high while the result for the current request is held
//
// Latency: finish rises after the 29th rising edge counted from the first
// edge that samples start=1. Edge 1 latches the decoded operands. Edges 2..27
// produce the 26 quotient bits, one per edge. Edge 28 normalises, rounds and
// writes result. Edge 29 raises finish.
// Denormals are flushed to zero. The rounding mode is round to nearest,
// ties to even. Results never come out denormal.
module fp32_div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        finish
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

  state_t             r_state, w_nxt;
  logic               r_armed;       // start was seen low while idle
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_mb;
  logic [25:0]        r_rem;
  logic [25:0]        r_q;
  logic [4:0]         r_cnt;
  logic               r_spec;
  logic [31:0]        r_spec_val;
  logic [31:0]        r_result;
  logic               r_finish;

  logic w_load, w_step, w_round, w_hold;

  // ---------------- operand decode (used only on the accepting edge)
  logic [7:0]  w_ea, w_eb;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic        w_sign, w_nan, w_spec;
  logic [31:0] w_spec_val;

  assign w_ea     = a[30:23];
  assign w_eb     = b[30:23];
  // exponent 0 covers both true zero and flushed denormals
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_a_inf  = (w_ea == 8'hFF) && (a[22:0] == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (b[22:0] == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (a[22:0] != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (b[22:0] != 23'd0);
  assign w_sign   = a[31] ^ b[31];
  assign w_nan    = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
  assign w_spec   = w_nan | w_a_zero | w_b_zero | w_a_inf | w_b_inf;

  always_comb begin
    w_spec_val = {w_sign, 31'd0};                       // 0/x, x/inf
    if (w_nan)                    w_spec_val = 32'h7FC00000;
    else if (w_b_zero | w_a_inf)  w_spec_val = {w_sign, 8'hFF, 23'd0};
  end

  // ---------------- restoring division step
  logic        w_ge;
  logic [25:0] w_rem_nxt;
  assign w_ge      = (r_rem >= {2'b00, r_mb});
  assign w_rem_nxt = (w_ge ? (r_rem - {2'b00, r_mb}) : r_rem) << 1;

  // ---------------- normalise + round to nearest even
  logic              w_norm, w_g, w_s, w_inc;
  logic [23:0]       w_sig, w_sig_r;
  logic signed [9:0] w_e1, w_e2;
  logic [31:0]       w_res;

  assign w_norm  = r_q[25];                      // quotient >= 1.0
  assign w_sig   = w_norm ? r_q[25:2] : r_q[24:1];
  assign w_g     = w_norm ? r_q[1] : r_q[0];
  assign w_s     = (w_norm & r_q[0]) | (|r_rem);
  assign w_inc   = w_g & (w_s | w_sig[0]);
  // an all-ones significand wraps to zero on increment; the cleared MSB
  // marks the carry-out, and the stored fraction is then correctly 0
  assign w_sig_r = w_sig + {23'd0, w_inc};
  assign w_e1    = r_exp - (w_norm ? 10'sd0 : 10'sd1);
  assign w_e2    = w_e1 + (w_sig_r[23] ? 10'sd0 : 10'sd1);

  always_comb begin
    w_res = {r_sign, w_e2[7:0], w_sig_r[22:0]};
    if (r_spec)                  w_res = r_spec_val;
    else if (w_e2 >= 10'sd255)   w_res = {r_sign, 8'hFF, 23'd0};
    else if (w_e2 <= 10'sd0)     w_res = {r_sign, 31'd0};
  end

  // ---------------- FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // ---------------- FSM: next state (start low anywhere returns to idle)
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start && r_armed) w_nxt = S_UNPACK;
      S_UNPACK: w_nxt = start ? S_DIVIDE : S_IDLE;
      S_DIVIDE: if (!start) w_nxt = S_IDLE;
                else if (r_cnt == 5'd25) w_nxt = S_ROUND;
      S_ROUND:  w_nxt = start ? S_DONE : S_IDLE;
      S_DONE:   if (!start) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: control outputs
  // UNPACK holds the freshly latched operands and already takes the first
  // quotient bit, so the 26 bits land on edges 2..27.
  always_comb begin
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_round = 1'b0;
    w_hold  = 1'b0;
    case (r_state)
      S_IDLE:   w_load  = start & r_armed;
      S_UNPACK,
      S_DIVIDE: w_step  = start;
      S_ROUND:  w_round = start;
      S_DONE:   w_hold  = start;
      default:  ;
    endcase
  end

  // ---------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed    <= 1'b0;
      r_sign     <= 1'b0;
      r_exp      <= 10'sd0;
      r_mb       <= 24'd0;
      r_rem      <= 26'd0;
      r_q        <= 26'd0;
      r_cnt      <= 5'd0;
      r_spec     <= 1'b0;
      r_spec_val <= 32'd0;
      r_result   <= 32'd0;
      r_finish   <= 1'b0;
    end else begin
      // a new request needs a low sample of start while idle
      r_armed  <= (r_state == S_IDLE) && !start;
      r_finish <= w_hold;
      if (w_load) begin
        r_sign     <= w_sign;
        r_exp      <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;
        r_rem      <= {2'b01, a[22:0], 1'b0} >> 1;
        r_mb       <= {1'b1, b[22:0]};
        r_q        <= 26'd0;
        r_cnt      <= 5'd0;
        r_spec     <= w_spec;
        r_spec_val <= w_spec_val;
      end
      if (w_step) begin
        r_rem <= w_rem_nxt;
        r_q   <= {r_q[24:0], w_ge};
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_round) r_result <= w_res;
    end
  end

  assign result = r_result;
  assign finish = r_finish;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Self-checking bench for fp32_div_seq: a behavioural quotient model
// (exact integer long division + round-to-nearest-even) and a handshake
// model counting edges since the accepting edge, compared every cycle,
// plus directed vectors with hand-computed expected quotients.
module tb_fp32_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] result;
  logic        finish;

  int total = 0;
  int bad   = 0;

  fp32_div_seq dut (
    .clk(clk), .reset(rst_n), .start(start),
    .a(a), .b(b), .result(result), .finish(finish)
  );

  always #5 clk = ~clk;

  // ---------------- quotient model
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    int ea, eb, e, sh;
    logic s, xz, yz, xi, yi, xn, yn;
    longint unsigned ma, mb, num, q, rem, sig, rest, half;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ea == 0);  yz = (eb == 0);
    xi = (ea == 255) && (x[22:0] == 0);
    yi = (eb == 255) && (y[22:0] == 0);
    xn = (ea == 255) && (x[22:0] != 0);
    yn = (eb == 255) && (y[22:0] != 0);
    if (xn || yn || (xz && yz) || (xi && yi)) return 32'h7FC00000;
    if (yz || xi) return {s, 8'hFF, 23'd0};
    if (xz || yi) return {s, 31'd0};
    ma = 0; ma[23:0] = {1'b1, x[22:0]};
    mb = 0; mb[23:0] = {1'b1, y[22:0]};
    num = ma << 40;
    q   = num / mb;
    rem = num % mb;
    e   = ea - eb + 127;
    if (q >= (64'd1 << 40)) sh = 17;
    else begin sh = 16; e = e - 1; end
    sig  = q >> sh;
    rest = q & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rest > half || (rest == half && (rem != 0 || sig[0]))) sig = sig + 1;
    if (sig == (64'd1 << 24)) begin sig = sig >> 1; e = e + 1; end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], sig[22:0]};
  endfunction

  // ---------------- handshake model: edges counted from the accepting edge
  logic        m_armed = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  int          m_k = 0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_armed <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
      m_k <= 0; m_res <= 32'd0;
    end else if (m_busy) begin
      if (!start) m_busy <= 1'b0;
      else begin
        m_k <= m_k + 1;
        if (m_k + 1 == 28) m_res <= model(m_a, m_b);
        if (m_k + 1 == 29) begin m_busy <= 1'b0; m_done <= 1'b1; end
      end
    end else if (m_done) begin
      if (!start) m_done <= 1'b0;
    end else begin
      m_armed <= !start;
      if (start && m_armed) begin
        m_busy <= 1'b1; m_k <= 1; m_a <= a; m_b <= b;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  // run one request; expects finish exactly 29 edges after acceptance
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] want, input string nm);
    int n;
    bit seen;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    n = 0; seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge clk); n++; #1;
      if (finish) seen = 1'b1;
    end
    check({nm, "_lat"}, 32'(n), 32'd29);
    check({nm, "_res"}, result, want);
    repeat (3) @(negedge clk);
    check({nm, "_hold"}, {31'd0, finish}, 32'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    bit seen;
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          check("cyc_finish", {31'd0, finish}, {31'd0, m_done});
          check("cyc_result", result, m_res);
        end
      end
    join_none

    // model pinned to hand-computed quotients
    check("model_1div3", model(32'h3F800000, 32'h40400000), 32'h3EAAAAAB);
    check("model_6div3", model(32'h40C00000, 32'h40400000), 32'h40000000);
    check("model_ovf",   model(32'h7F7FFFFF, 32'h3F000000), 32'h7F800000);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_finish", {31'd0, finish}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(32'h3F800000, 32'h40000000, 32'h3F000000, "1div2");
    run_op(32'h40C00000, 32'h40400000, 32'h40000000, "6div3");
    run_op(32'hBF800000, 32'h00000000, 32'hFF800000, "m1div0");
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, "0div0");
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, "infdivinf");
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nandiv1");
    run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, "maxdivhalf");
    run_op(32'h00800000, 32'h40000000, 32'h00000000, "mindiv2");
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "1div3");

    // abort: start sampled low on edge 10
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40400000; start = 1'b1;
    repeat (9) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_finish", {31'd0, finish}, 32'd0);
    check("abort_result", result, 32'h3EAAAAAB);

    // operand changed after the accepting edge is ignored
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    a = 32'h40C00000;
    n = 1; seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge clk); n++; #1;
      if (finish) seen = 1'b1;
    end
    check("stable_lat", 32'(n), 32'd29);
    check("stable_res", result, 32'h3EAAAAAB);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid-DIVIDE with start held high
    start = 1'b1;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_finish", {31'd0, finish}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rearm_finish", {31'd0, finish}, 32'd0);
    check("rearm_result", result, 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    run_op(32'h3F800000, 32'h40000000, 32'h3F000000, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
